pretrig_ring_buffer: RTL

//  Multi-channel circular sample store between the hydrophone ADC front end and the ping detector.

---
 rtl/pretrig_ring_buffer_pkg.sv | 30 +++
 rtl/pretrig_ring_buffer_sdp_ram.sv | 33 +++
 rtl/pretrig_ring_buffer.sv | 237 +++++++++++++++++++++++
 3 files changed

// File: rtl/pretrig_ring_buffer_pkg.sv
// Shared definitions for the pre-trigger ring buffer: FSM encoding, address sizing,
// and channel packing helpers.
package pretrig_ring_buffer_pkg;

    localparam logic [1:0] RB_ST_FILL  = 2'd0;
    localparam logic [1:0] RB_ST_ARMED = 2'd1;
    localparam logic [1:0] RB_ST_POST  = 2'd2;
    localparam logic [1:0] RB_ST_READ  = 2'd3;

    typedef enum logic [1:0] {
        ST_FILL  = RB_ST_FILL,
        ST_ARMED = RB_ST_ARMED,
        ST_POST  = RB_ST_POST,
        ST_READ  = RB_ST_READ
    } rb_state_e;

    function automatic int addr_w(input int depth);
        return (depth <= 2) ? 1 : $clog2(depth);
    endfunction

    // Channel ch occupies bits [ch_lsb +: data_w] of a packed sample word.
    function automatic int ch_lsb(input int ch, input int data_w);
        return ch * data_w;
    endfunction

    function automatic int ch_msb(input int ch, input int data_w);
        return ch * data_w + data_w - 1;
    endfunction

endpackage

// File: rtl/pretrig_ring_buffer_sdp_ram.sv
// Simple dual-port sample store: one write port, one registered read port.
// No reset on the array so it maps onto block RAM.
module rb_sdp_ram
    import pretrig_ring_buffer_pkg::*;
#(
    parameter int DEPTH  = 1024,
    parameter int WIDTH  = 40,
    parameter int ADDR_W = addr_w(DEPTH)
) (
    input  logic              clk_i,
    input  logic              we_i,
    input  logic [ADDR_W-1:0] waddr_i,
    input  logic [WIDTH-1:0]  wdata_i,
    input  logic              re_i,
    input  logic [ADDR_W-1:0] raddr_i,
    output logic [WIDTH-1:0]  rdata_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] rdata_q;

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
        if (re_i) begin
            rdata_q <= mem_q[raddr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/pretrig_ring_buffer.sv
// Multi-channel pre-trigger ring buffer: records continuously, freezes a frame around
// Trigger, drains it oldest-first on a valid/ready stream. Macro: RB_OVERFLOW_STICKY_EN.
//
//  state | meaning
//  ------+-----------------------------------------------------------
//  FILL  | collecting history until DEPTH-POST_TRIG samples are held
//  ARMED | history full, writes continue, waiting for Trigger
//  POST  | capturing POST_TRIG samples after the trigger
//  READ  | frame frozen, draining DEPTH beats; inputs are dropped
module pretrig_ring_buffer
    import pretrig_ring_buffer_pkg::*;
#(
    parameter int CHANNELS  = 4,
    parameter int DATA_W    = 10,
    parameter int DEPTH     = 1024,
    parameter int POST_TRIG = 256
) (
    input  logic                         CLK,
    input  logic                         RST,
    input  logic [CHANNELS*DATA_W-1:0]   Input_Data,
    input  logic                         Input_Valid,
    input  logic                         Trigger,
    output logic                         Armed,
    output logic                         Frame_Ready,
    output logic [CHANNELS*DATA_W-1:0]   Out_Data,
    output logic                         Out_Valid,
    input  logic                         Out_Ready,
    output logic                         Out_Last,
    output logic                         RAM_Overflow
);

    localparam int W  = CHANNELS * DATA_W;
    localparam int AW = addr_w(DEPTH);
    localparam int CW = AW + 1;

    localparam logic [CW-1:0] DEPTH_C     = CW'(DEPTH);
    localparam logic [CW-1:0] FILL_TARGET = CW'(DEPTH - POST_TRIG);
    localparam logic [AW-1:0] POST_C      = AW'(POST_TRIG);

    rb_state_e     state_q, state_d;
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] fill_cnt_q, fill_cnt_d;
    logic [AW-1:0] post_cnt_q, post_cnt_d;
    logic [CW-1:0] issue_left_q, issue_left_d;

    logic          infl_q, infl_d;
    logic          infl_last_q, infl_last_d;
    logic          out_valid_q, out_valid_d;
    logic          out_last_q, out_last_d;
    logic [W-1:0]  out_data_q, out_data_d;
    logic          skid_valid_q, skid_valid_d;
    logic          skid_last_q, skid_last_d;
    logic [W-1:0]  skid_data_q, skid_data_d;
    logic          ovf_q, ovf_d;

    logic          ram_we;
    logic          issue;
    logic          pop;
    logic          drop;
    logic [1:0]    occ;
    logic [1:0]    occ_left;
    logic [W-1:0]  ram_rdata;

    assign ram_we   = Input_Valid && (state_q != ST_READ);
    assign drop     = Input_Valid && (state_q == ST_READ);
    assign pop      = out_valid_q && Out_Ready;
    assign occ      = {1'b0, out_valid_q} + {1'b0, skid_valid_q} + {1'b0, infl_q};
    assign occ_left = occ - {1'b0, pop};
    // A read may only be launched if its data is guaranteed a slot even with no pop next cycle.
    assign issue    = (state_q == ST_READ) && (issue_left_q != '0) && (occ_left <= 2'd1);

    rb_sdp_ram #(
        .DEPTH  (DEPTH),
        .WIDTH  (W),
        .ADDR_W (AW)
    ) u_ram (
        .clk_i   (CLK),
        .we_i    (ram_we),
        .waddr_i (wr_ptr_q),
        .wdata_i (Input_Data),
        .re_i    (issue),
        .raddr_i (rd_ptr_q),
        .rdata_o (ram_rdata)
    );

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q      <= ST_FILL;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            fill_cnt_q   <= '0;
            post_cnt_q   <= '0;
            issue_left_q <= '0;
            infl_q       <= 1'b0;
            infl_last_q  <= 1'b0;
            out_valid_q  <= 1'b0;
            out_last_q   <= 1'b0;
            out_data_q   <= '0;
            skid_valid_q <= 1'b0;
            skid_last_q  <= 1'b0;
            skid_data_q  <= '0;
            ovf_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            fill_cnt_q   <= fill_cnt_d;
            post_cnt_q   <= post_cnt_d;
            issue_left_q <= issue_left_d;
            infl_q       <= infl_d;
            infl_last_q  <= infl_last_d;
            out_valid_q  <= out_valid_d;
            out_last_q   <= out_last_d;
            out_data_q   <= out_data_d;
            skid_valid_q <= skid_valid_d;
            skid_last_q  <= skid_last_d;
            skid_data_q  <= skid_data_d;
            ovf_q        <= ovf_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        wr_ptr_d   = wr_ptr_q;
        fill_cnt_d = fill_cnt_q;
        post_cnt_d = post_cnt_q;

        if (ram_we) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
            if (fill_cnt_q != DEPTH_C) begin
                fill_cnt_d = fill_cnt_q + 1'b1;
            end
        end

        case (state_q)
            ST_FILL: begin
                if (ram_we && (fill_cnt_d == FILL_TARGET)) begin
                    state_d = ST_ARMED;
                end
            end
            ST_ARMED: begin
                // The write in the trigger cycle is history, so post_cnt is untouched here.
                if (Trigger) begin
                    state_d = ST_POST;
                end
            end
            ST_POST: begin
                if (ram_we) begin
                    post_cnt_d = post_cnt_q + 1'b1;
                    if (post_cnt_d == POST_C) begin
                        state_d = ST_READ;
                    end
                end
            end
            ST_READ: begin
                if (pop && out_last_q) begin
                    state_d    = ST_FILL;
                    fill_cnt_d = '0;
                    post_cnt_d = '0;
                end
            end
            default: begin
                state_d = ST_FILL;
            end
        endcase
    end

    always_comb begin
        rd_ptr_d     = wr_ptr_d;
        issue_left_d = issue_left_q;
        infl_d       = issue;
        infl_last_d  = issue && (issue_left_q == CW'(1));

        if (state_q == ST_READ) begin
            rd_ptr_d = issue ? rd_ptr_q + 1'b1 : rd_ptr_q;
        end
        if (issue) begin
            issue_left_d = issue_left_q - 1'b1;
        end
        if ((state_q != ST_READ) && (state_d == ST_READ)) begin
            issue_left_d = DEPTH_C;
        end
    end

    always_comb begin
        out_valid_d  = out_valid_q;
        out_last_d   = out_last_q;
        out_data_d   = out_data_q;
        skid_valid_d = skid_valid_q;
        skid_last_d  = skid_last_q;
        skid_data_d  = skid_data_q;

        if (!out_valid_q || pop) begin
            if (skid_valid_q) begin
                out_valid_d  = 1'b1;
                out_last_d   = skid_last_q;
                out_data_d   = skid_data_q;
                skid_valid_d = infl_q;
                skid_last_d  = infl_last_q;
                skid_data_d  = ram_rdata;
            end else if (infl_q) begin
                out_valid_d = 1'b1;
                out_last_d  = infl_last_q;
                out_data_d  = ram_rdata;
            end else begin
                out_valid_d = 1'b0;
                out_last_d  = 1'b0;
            end
        end else if (infl_q) begin
            skid_valid_d = 1'b1;
            skid_last_d  = infl_last_q;
            skid_data_d  = ram_rdata;
        end
    end

`ifdef RB_OVERFLOW_STICKY_EN
    always_comb begin
        ovf_d = ovf_q | drop;
        if ((state_q == ST_READ) && (state_d == ST_FILL)) begin
            ovf_d = 1'b0;
        end
    end
`else
    always_comb begin
        ovf_d = drop;
    end
`endif

    assign Armed        = (state_q == ST_ARMED);
    assign Frame_Ready  = (state_q == ST_READ);
    assign Out_Data     = out_data_q;
    assign Out_Valid    = out_valid_q;
    assign Out_Last     = out_last_q;
    assign RAM_Overflow = ovf_q;

endmodule
